// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART serial transmit stage.
// Accepts bytes through a valid/ready handshake into a one-entry holding buffer.
// Each byte is framed as one start bit, eight data bits sent LSB first, an
// optional parity bit, and STOP_BITS stop bits. The bit period is
// CLKS_PER_BIT cycles of clk_sis.
//
// Ports:
//   clk_sis    in   system clock; all logic on its rising edge
//   rst        in   synchronous, active-high reset
//   data_in    in   [7:0] byte to send; sampled only on the accept edge
//   data_valid in   producer has a byte on data_in
//   data_ready out  holding buffer empty; byte accepted on data_valid & data_ready
//   tx         out  serial line; idle high
//   busy       out  a frame is on the line (start through last stop cycle)
//   done       out  one-cycle pulse on the last cycle of the final stop bit
//
// Build option: define UART_PARITY_EN to insert a parity bit after the data
// bits. PARITY_ODD selects odd parity (1) or even parity (0).
//
// All outputs are registered from the current FSM state, so the line lags
// the state register by one cycle. A byte accepted at edge N is loaded at
// N+1, and tx falls at N+2.

module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk_sis,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] DATA_NEXT = S_PARITY;
`else
    // Without the parity slot, PARITY_ODD has no effect on the frame.
    localparam logic [2:0] DATA_NEXT = PARITY_ODD ? S_STOP : S_STOP;
`endif

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    buf_data;
    logic          buf_full;
`ifdef UART_PARITY_EN
    logic          par_bit;
`endif

    logic accept;
    logic bit_end;
    logic stop_end;
    logic load;
    logic buf_full_nxt;

    always_comb begin
        accept   = data_valid && data_ready;
        bit_end  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
        stop_end = (state == S_STOP) && bit_end && (bit_cnt == 3'(STOP_BITS - 1));
        // The buffer drains from IDLE, or straight out of the final stop cycle
        // so that back-to-back frames have no idle gap.
        load     = buf_full && ((state == S_IDLE) || stop_end);
        // accept and load are exclusive: accept needs an empty buffer and load
        // needs a full one.
        buf_full_nxt = buf_full;
        if (load) begin
            buf_full_nxt = 1'b0;
        end
        if (accept) begin
            buf_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_sis) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            buf_data   <= '0;
            buf_full   <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit    <= 1'b0;
`endif
            data_ready <= 1'b1;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            buf_full   <= buf_full_nxt;
            data_ready <= !buf_full_nxt;
            busy       <= (state != S_IDLE);
            done       <= stop_end;

            case (state)
                S_START:  tx <= 1'b0;
                S_DATA:   tx <= shift[0];
`ifdef UART_PARITY_EN
                S_PARITY: tx <= par_bit;
`endif
                default:  tx <= 1'b1;
            endcase

            if (accept) begin
                buf_data <= data_in;
            end

            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (buf_full) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= DATA_NEXT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (stop_end) begin
                            bit_cnt <= '0;
                            state   <= buf_full ? S_START : S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (load) begin
                shift <= buf_data;
`ifdef UART_PARITY_EN
                par_bit <= (^buf_data) ^ PARITY_ODD;
`endif
            end
        end
    end

endmodule
